// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: CPU clock-enable generator for the board top.
// Produces a one-clk-wide cpuEn per CPU cycle from one of four modes:
// single-step from a debounced push button, slow or fast prescaled ticks,
// or full speed. Every output is a flop in the clk domain, so the enable
// driving the CPU core's clock gate never glitches.
//
// Optional feature: define CPU_CLK_CTRL_STEP_CNT_EN to add a 16-bit
// stepCnt output counting enabled CPU cycles (cleared on mode change).
//
// Debounce FSM states:
//   state  | meaning
//   UP     | button released and stable
//   UP_CHK | button seen pressed, counting stable-low cycles
//   DOWN   | button pressed and stable (step already issued)
//   DN_CHK | button seen released, counting stable-high cycles

module cpu_clk_ctrl #(
  parameter int DEB_CYCLES = 500_000,
  parameter int DIV_SLOW   = 50_000_000,
  parameter int DIV_FAST   = 5_000_000,
  parameter int CNT_W      = 26
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       clkBtn,
  input  logic [1:0] clkSel,
  output logic       cpuEn,
  output logic [1:0] modeOut,
  output logic       btnLvl
`ifdef CPU_CLK_CTRL_STEP_CNT_EN
  ,
  output logic [15:0] stepCnt
`endif
);

  localparam logic [1:0] MODE_STEP = 2'b00;
  localparam logic [1:0] MODE_SLOW = 2'b01;
  localparam logic [1:0] MODE_FAST = 2'b10;
  localparam logic [1:0] MODE_FULL = 2'b11;

  localparam logic [CNT_W-1:0] DEB_TC      = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_SLOW_TC = CNT_W'(DIV_SLOW - 1);
  localparam logic [CNT_W-1:0] DIV_FAST_TC = CNT_W'(DIV_FAST - 1);

  typedef enum logic [1:0] {
    UP     = 2'd0,
    UP_CHK = 2'd1,
    DOWN   = 2'd2,
    DN_CHK = 2'd3
  } debState_t;

  logic             btnMeta;
  logic             btnSync;
  logic [1:0]       selMeta;
  logic [1:0]       selSync;

  debState_t        debState;
  logic [CNT_W-1:0] debCnt;
  logic             stepReq;

  logic [CNT_W-1:0] divCnt;
  logic [CNT_W-1:0] divTc;
  logic             divMode;
  logic             tick;
  logic             modeApply;

  // Two-flop synchronisers for the asynchronous button and mode switch;
  // reset to the idle levels so nothing fires right after reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      btnMeta <= 1'b1;
      btnSync <= 1'b1;
      selMeta <= 2'b00;
      selSync <= 2'b00;
    end else begin
      btnMeta <= clkBtn;
      btnSync <= btnMeta;
      selMeta <= clkSel;
      selSync <= selMeta;
    end
  end

  // The step request is the terminal-count cycle of a confirmed press; it is
  // registered into cpuEn, so the CPU sees it one cycle later.
  assign stepReq = (debState == UP_CHK) && !btnSync && (debCnt == DEB_TC);

  // Debounce FSM: a level change is accepted only after DEB_CYCLES stable
  // cycles; btnLvl is registered alongside the state it reflects.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      debState <= UP;
      debCnt   <= '0;
      btnLvl   <= 1'b1;
    end else begin
      case (debState)
        UP: begin
          if (!btnSync) begin
            debState <= UP_CHK;
            debCnt   <= '0;
          end
        end
        UP_CHK: begin
          if (btnSync) begin
            debState <= UP;
          end else if (debCnt == DEB_TC) begin
            debState <= DOWN;
            btnLvl   <= 1'b0;
          end else begin
            debCnt <= debCnt + 1'b1;
          end
        end
        DOWN: begin
          if (btnSync) begin
            debState <= DN_CHK;
            debCnt   <= '0;
          end
        end
        DN_CHK: begin
          if (!btnSync) begin
            debState <= DOWN;
          end else if (debCnt == DEB_TC) begin
            debState <= UP;
            btnLvl   <= 1'b1;
          end else begin
            debCnt <= debCnt + 1'b1;
          end
        end
        default: begin
          debState <= UP;
          debCnt   <= '0;
          btnLvl   <= 1'b1;
        end
      endcase
    end
  end

  // A new switch setting is applied on the first cycle it differs from the
  // mode in use; that cycle restarts the prescaler and forces a dead cycle.
  assign modeApply = (selSync != modeOut);

  // Select the prescaler terminal count for the active mode.
  always_comb begin
    divTc   = '0;
    divMode = 1'b0;
    case (modeOut)
      MODE_SLOW: begin
        divTc   = DIV_SLOW_TC;
        divMode = 1'b1;
      end
      MODE_FAST: begin
        divTc   = DIV_FAST_TC;
        divMode = 1'b1;
      end
      default: begin
        divTc   = '0;
        divMode = 1'b0;
      end
    endcase
    tick = divMode && (divCnt == divTc);
  end

  // Prescaler: wraps at DIV-1 in the divided modes, parked at 0 otherwise.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      divCnt <= '0;
    end else if (modeApply || !divMode || tick) begin
      divCnt <= '0;
    end else begin
      divCnt <= divCnt + 1'b1;
    end
  end

  // Applied mode and the registered CPU enable; a step request arriving on
  // an apply cycle is simply not propagated, so the mode change wins.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      modeOut <= MODE_STEP;
      cpuEn   <= 1'b0;
    end else if (modeApply) begin
      modeOut <= selSync;
      cpuEn   <= 1'b0;
    end else begin
      case (modeOut)
        MODE_STEP: cpuEn <= stepReq;
        MODE_SLOW: cpuEn <= tick;
        MODE_FAST: cpuEn <= tick;
        MODE_FULL: cpuEn <= 1'b1;
        default:   cpuEn <= 1'b0;
      endcase
    end
  end

`ifdef CPU_CLK_CTRL_STEP_CNT_EN
  // Count enabled CPU cycles for display; restarts whenever the mode changes.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stepCnt <= '0;
    end else if (modeApply) begin
      stepCnt <= '0;
    end else if (cpuEn) begin
      stepCnt <= stepCnt + 16'd1;
    end
  end
`else
  // Step counter not built in this configuration.
`endif

endmodule
